// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point class encoding, flag indices and constant helpers
package fp_pkg;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } fp_class_e;

    localparam int FLAGS_W        = 4;
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set; caller truncates to W bits.
    function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
        r[man_w - 1] = 1'b1;
        return r;
    endfunction

    // Subnormals classify as zero so the arithmetic path flushes them.
    function automatic fp_class_e fp_classify(input logic exp_ones, input logic exp_zero,
                                              input logic man_zero, input logic man_msb);
        if (exp_ones) begin
            if (man_zero) return CLS_INF;
            return man_msb ? CLS_QNAN : CLS_SNAN;
        end
        if (exp_zero) return CLS_ZERO;
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter
module fp_lzc #(
    parameter int WIDTH = 11,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_pipe_param.sv
// rtl/fp_addsub_pipe_param.sv - four-stage parametrised FP adder/subtractor, RNE, FTZ, valid/ready
module fp_addsub_pipe_param
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int TAG_W = 4,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       x1,
    input  logic [W-1:0]       x2,
    input  logic               add_sub,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       y,
    output logic [TAG_W-1:0]   out_tag,
    output logic [FLAGS_W-1:0] flags
);

    localparam int SW = MAN_W + 4;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(SW + 1);
    localparam logic [W-1:0]          QNAN     = W'(fp_canon_nan(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0]      EXP_ONES = '1;
    localparam logic signed [EW-1:0]  EXP_MAX  = EW'((1 << EXP_W) - 1);

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // S1: unpack, classify, resolve specials, order operands so |A| >= |B|
    logic             sa, sb, swap;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic [W-2:0]     mag_a, mag_b;
    logic [MAN_W:0]   sig_a, sig_b;
    fp_class_e        ca, cb;
    logic             spec;
    logic [W-1:0]     spec_y;
    logic [FLAGS_W-1:0] spec_flags;

    assign {sa, ea, ma} = x1;
    assign sb           = x2[W-1] ^ add_sub;
    assign {eb, mb}     = x2[W-2:0];
    assign ca    = fp_classify(&ea, ~|ea, ~|ma, ma[MAN_W-1]);
    assign cb    = fp_classify(&eb, ~|eb, ~|mb, mb[MAN_W-1]);
    assign mag_a = (ca == CLS_ZERO) ? '0 : {ea, ma};
    assign mag_b = (cb == CLS_ZERO) ? '0 : {eb, mb};
    assign sig_a = (ca == CLS_ZERO) ? '0 : {1'b1, ma};
    assign sig_b = (cb == CLS_ZERO) ? '0 : {1'b1, mb};
    assign swap  = mag_b > mag_a;

    always_comb begin
        spec       = 1'b1;
        spec_y     = '0;
        spec_flags = '0;
        if (ca == CLS_SNAN || cb == CLS_SNAN) begin
            spec_y                   = QNAN;
            spec_flags[FLAG_INVALID] = 1'b1;
        end else if (ca == CLS_QNAN || cb == CLS_QNAN) begin
            spec_y = QNAN;
        end else if (ca == CLS_INF && cb == CLS_INF) begin
            spec_y                   = (sa != sb) ? QNAN : {sa, EXP_ONES, {MAN_W{1'b0}}};
            spec_flags[FLAG_INVALID] = (sa != sb);
        end else if (ca == CLS_INF) begin
            spec_y = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (cb == CLS_INF) begin
            spec_y = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end else if (ca == CLS_ZERO && cb == CLS_ZERO) begin
            spec_y = {sa & sb, {(W-1){1'b0}}};
        end else begin
            spec = 1'b0;
        end
    end

    logic               s1_valid, s1_spec, s1_sign, s1_sub;
    logic [TAG_W-1:0]   s1_tag;
    logic [W-1:0]       s1_spec_y;
    logic [FLAGS_W-1:0] s1_spec_flags;
    logic [EXP_W-1:0]   s1_exp, s1_diff;
    logic [MAN_W:0]     s1_sig_a, s1_sig_b;

    // S2: align B; everything shifted past the extended width collapses into sticky
    logic [SW-1:0] b_ext, b_mask, b_al;
    assign b_ext  = {s1_sig_b, 3'b000};
    assign b_mask = ~({SW{1'b1}} << s1_diff);
    assign b_al   = (b_ext >> s1_diff) | SW'(|(b_ext & b_mask));

    logic               s2_valid, s2_spec, s2_sign, s2_sub;
    logic [TAG_W-1:0]   s2_tag;
    logic [W-1:0]       s2_spec_y;
    logic [FLAGS_W-1:0] s2_spec_flags;
    logic [EXP_W-1:0]   s2_exp;
    logic [MAN_W:0]     s2_sig_a;
    logic [SW-1:0]      s2_b_al;

    // S3: add/subtract, normalise to hidden bit at SW-1
    logic [SW:0]            sum;
    logic [CW-1:0]          lz;
    logic [SW-1:0]          norm_man;
    logic signed [EW-1:0]   norm_exp;

    assign sum = s2_sub ? ({1'b0, s2_sig_a, 3'b000} - {1'b0, s2_b_al})
                        : ({1'b0, s2_sig_a, 3'b000} + {1'b0, s2_b_al});

    fp_lzc #(.WIDTH(SW), .CNT_W(CW)) u_lzc (
        .value (sum[SW-1:0]),
        .count (lz)
    );

    always_comb begin
        if (sum[SW]) begin
            norm_man = {sum[SW:2], sum[1] | sum[0]};
            norm_exp = EW'(s2_exp) + EW'(1);
        end else begin
            norm_man = sum[SW-1:0] << lz;
            norm_exp = EW'(s2_exp) - EW'(lz);
        end
    end

    logic                 s3_valid, s3_spec, s3_sign, s3_zero;
    logic [TAG_W-1:0]     s3_tag;
    logic [W-1:0]         s3_spec_y;
    logic [FLAGS_W-1:0]   s3_spec_flags;
    logic signed [EW-1:0] s3_exp;
    logic [SW-1:0]        s3_man;

    // S4: round to nearest even, renormalise on mantissa carry, pack and flag
    logic                 g, r, st;
    logic [MAN_W+1:0]     rnd;
    logic signed [EW-1:0] exp_r;
    logic [MAN_W-1:0]     frac_r;
    logic [W-1:0]         y_n;
    logic [FLAGS_W-1:0]   flags_n;

    assign g      = s3_man[2];
    assign r      = s3_man[1];
    assign st     = s3_man[0];
    assign rnd    = {1'b0, s3_man[SW-1:3]} + (MAN_W+2)'(g & (r | st | s3_man[3]));
    assign exp_r  = s3_exp + EW'(rnd[MAN_W+1]);
    assign frac_r = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];

    always_comb begin
        y_n     = '0;
        flags_n = '0;
        if (s3_spec) begin
            y_n     = s3_spec_y;
            flags_n = s3_spec_flags;
        end else if (s3_zero) begin
            y_n = '0;
        end else if (s3_exp[EW-1] || s3_exp == '0) begin
            y_n                     = {s3_sign, {(W-1){1'b0}}};
            flags_n[FLAG_UNDERFLOW] = 1'b1;
            flags_n[FLAG_INEXACT]   = 1'b1;
        end else if (exp_r >= EXP_MAX) begin
            y_n                    = {s3_sign, EXP_ONES, {MAN_W{1'b0}}};
            flags_n[FLAG_OVERFLOW] = 1'b1;
            flags_n[FLAG_INEXACT]  = 1'b1;
        end else begin
            y_n                   = {s3_sign, exp_r[EXP_W-1:0], frac_r};
            flags_n[FLAG_INEXACT] = g | r | st;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0; s1_tag <= '0; s1_spec <= 1'b0; s1_spec_y <= '0; s1_spec_flags <= '0;
            s1_sign <= 1'b0; s1_sub <= 1'b0; s1_exp <= '0; s1_diff <= '0;
            s1_sig_a <= '0; s1_sig_b <= '0;
            s2_valid <= 1'b0; s2_tag <= '0; s2_spec <= 1'b0; s2_spec_y <= '0; s2_spec_flags <= '0;
            s2_sign <= 1'b0; s2_sub <= 1'b0; s2_exp <= '0; s2_sig_a <= '0; s2_b_al <= '0;
            s3_valid <= 1'b0; s3_tag <= '0; s3_spec <= 1'b0; s3_spec_y <= '0; s3_spec_flags <= '0;
            s3_sign <= 1'b0; s3_zero <= 1'b0; s3_exp <= '0; s3_man <= '0;
            out_valid <= 1'b0; y <= '0; out_tag <= '0; flags <= '0;
        end else if (advance) begin
            s1_valid      <= in_valid;
            s1_tag        <= in_tag;
            s1_spec       <= spec;
            s1_spec_y     <= spec_y;
            s1_spec_flags <= spec_flags;
            s1_sign       <= swap ? sb : sa;
            s1_sub        <= sa ^ sb;
            s1_exp        <= swap ? mag_b[W-2:MAN_W] : mag_a[W-2:MAN_W];
            s1_diff       <= swap ? (mag_b[W-2:MAN_W] - mag_a[W-2:MAN_W])
                                  : (mag_a[W-2:MAN_W] - mag_b[W-2:MAN_W]);
            s1_sig_a      <= swap ? sig_b : sig_a;
            s1_sig_b      <= swap ? sig_a : sig_b;

            s2_valid      <= s1_valid;
            s2_tag        <= s1_tag;
            s2_spec       <= s1_spec;
            s2_spec_y     <= s1_spec_y;
            s2_spec_flags <= s1_spec_flags;
            s2_sign       <= s1_sign;
            s2_sub        <= s1_sub;
            s2_exp        <= s1_exp;
            s2_sig_a      <= s1_sig_a;
            s2_b_al       <= b_al;

            s3_valid      <= s2_valid;
            s3_tag        <= s2_tag;
            s3_spec       <= s2_spec;
            s3_spec_y     <= s2_spec_y;
            s3_spec_flags <= s2_spec_flags;
            s3_sign       <= s2_sign;
            s3_zero       <= (sum == '0);
            s3_exp        <= norm_exp;
            s3_man        <= norm_man;

            out_valid     <= s3_valid;
            y             <= y_n;
            out_tag       <= s3_tag;
            flags         <= flags_n;
        end
    end

endmodule
